// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID definitions: fetch and IF/ID buffer state encodings plus reset constants.
package if_id_skid_reg_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_ONE   = 2'd1,
    IFID_FULL  = 2'd2
  } ifid_state_e;

  localparam logic [31:0] IFID_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] IFID_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: two-entry skid buffer (main drives decode, skid holds overflow)
// with registered in_ready/occupancy and a synchronous flush.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IFID_RESET_PC),
  parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(IFID_NOP_INST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_inst,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  ifid_state_e      state;
  logic [WIDTH-1:0] skid_pc;
  logic [WIDTH-1:0] skid_inst;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // out_pc/out_inst are the main entry itself; out_inst is parked at NOP_INST
  // whenever the buffer drains so decode never sees a stale instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IFID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      out_pc    <= RESET_PC;
      out_inst  <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else if (flush) begin
      state     <= IFID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      out_inst  <= NOP_INST;
    end else begin
      unique case (state)
        IFID_EMPTY: begin
          if (in_fire) begin
            state     <= IFID_ONE;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
            out_pc    <= in_pc;
            out_inst  <= in_inst;
          end
        end
        IFID_ONE: begin
          if (in_fire && out_fire) begin
            out_pc   <= in_pc;
            out_inst <= in_inst;
          end else if (in_fire) begin
            state     <= IFID_FULL;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
          end else if (out_fire) begin
            state     <= IFID_EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            out_inst  <= NOP_INST;
          end
        end
        IFID_FULL: begin
          if (out_fire) begin
            state     <= IFID_ONE;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
            out_pc    <= skid_pc;
            out_inst  <= skid_inst;
          end
        end
        default: begin
          state     <= IFID_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
          out_inst  <= NOP_INST;
        end
      endcase
    end
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline register between the fetch unit and the decode unit.
- Captures each fetched {pc, inst} beat when the fetch side asserts its write-enable/valid, and presents it to decode with a valid/ready handshake.
- Two-entry skid buffer, so decode back-pressure never loses a beat and in_ready is a pure register output.
- Supports a synchronous flush from later stages (branch/jump redirect).

Parameters:
WIDTH, 32, width of pc and instruction words
RESET_PC, 32'h80000000, value driven on out_pc while empty after reset
NOP_INST, 32'h00000013, value driven on out_inst whenever out_valid=0

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
in_valid  input  1  fetch beat valid (driven by the fetch write-enable)
in_ready  output  1  buffer can accept a beat this cycle; registered
in_pc  input  WIDTH  pc of fetched instruction
in_inst  input  WIDTH  fetched instruction word
out_valid  output  1  beat presented to decode
out_ready  input  1  decode accepts the beat
out_pc  output  WIDTH  pc to decode
out_inst  output  WIDTH  instruction to decode
flush  input  1  discard all held and incoming beats
occupancy  output  2  entries held, 0..2

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry drives out_*; skid entry holds overflow. FSM states are EMPTY, ONE, FULL.
- Reset (rst=0, async): state EMPTY, out_valid=0, out_pc=RESET_PC, out_inst=NOP_INST, in_ready=1, occupancy=0. Release is synchronous to clk; the first beat can be accepted on the first rising edge with rst=1.
- EMPTY:
  - in_fire -> ONE; main <= in.
- ONE:
  - in_fire & out_fire -> ONE; main <= in.
  - in_fire & !out_fire -> FULL; skid <= in.
  - !in_fire & out_fire -> EMPTY.
- FULL:
  - in_ready=0.
  - out_fire -> ONE; main <= skid.
  - no out_fire -> stay.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. It is updated on the same edge as the state.
- Latency: a beat accepted at edge N is visible on out_* after edge N (one cycle).
- Zero-bubble throughput: with out_ready held at 1 and in_valid held at 1, one beat per cycle.
- Ordering: strictly FIFO. Skid content is never presented before main.
- Stability: while out_valid=1 and out_ready=0, out_pc and out_inst hold constant.
- When out_valid=0, out_inst=NOP_INST and out_pc holds its last value (RESET_PC after reset).
- flush=1 at an edge: state <= EMPTY, both entries invalidated, in_ready <= 1.
  - A simultaneous in_fire beat is dropped.
  - A simultaneous out_fire still counts as consumed by decode.
  - flush overrides every other transition.
- occupancy = 0/1/2 for EMPTY/ONE/FULL; registered.
- Illegal state encoding recovers to EMPTY on the next edge, with in_ready=1.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock.

Decomposition:
- Shared package/defines file holds:
  - state encodings IFID_EMPTY=2'd0, IFID_ONE=2'd1, IFID_FULL=2'd2, alongside the existing fetch-state defines;
  - NOP_INST constant;
  - RESET_PC constant.
- No sub-module required. Optionally factor a one-entry register slice (if_id_entry: valid+pc+inst with load enable) and instantiate it twice as main and skid.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> out_valid=0, out_pc=32'h80000000, out_inst=32'h00000013, in_ready=1, occupancy=0.
- Streaming: out_ready=1; in_valid=1 with pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles -> out_pc shows the same sequence one cycle later; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0; send pc 0x80000000 then 0x80000004 -> occupancy=2, in_ready=0, a third beat 0x80000008 is not accepted. Raise out_ready -> outputs 0x80000000, then 0x80000004, then 0x80000008 once re-offered; no loss, no duplication.
- Flush while FULL: occupancy=2, assert flush together with in_valid (pc 0x80000010) -> next cycle out_valid=0, occupancy=0, in_ready=1, pc 0x80000010 never appears on out_pc.
- Async reset mid-stream: drop rst between clock edges while occupancy=1 -> out_valid=0 and in_ready=1 immediately, before the next edge.
- Stability: out_valid=1 with out_ready=0 for 5 cycles while in_pc/in_inst toggle -> out_pc and out_inst unchanged throughout.
